// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - RISC-V immediate decoder feeding a two-entry output FIFO
// Decode happens before storage so out_* come straight from registers.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_ext_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic             err_sticky
);

  localparam int EW = XLEN + TAG_W + 1;

  logic signed [31:0] sx32;
  logic [XLEN-1:0]    dec_imm;
  logic               dec_illegal;
  logic [EW-1:0]      new_ent;

  logic [EW-1:0]      ent0_q, ent0_d;
  logic [EW-1:0]      ent1_q, ent1_d;
  logic [1:0]         count_q, count_d;
  logic               err_q, err_d;
  logic               push, pop;

  always_comb begin
    sx32        = '0;
    dec_imm     = '0;
    dec_illegal = 1'b0;
    case (in_ext_op)
      3'b000: begin
        sx32    = {{20{in_instr[31]}}, in_instr[31:20]};
        dec_imm = XLEN'(sx32);
      end
      3'b001: begin
        sx32    = {in_instr[31:12], 12'b0};
        dec_imm = XLEN'(sx32);
      end
      3'b010: begin
        sx32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec_imm = XLEN'(sx32);
      end
      3'b011: begin
        sx32    = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        dec_imm = XLEN'(sx32);
      end
      3'b100: begin
        sx32    = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        dec_imm = XLEN'(sx32);
      end
      3'b101: begin
        // RV32 has only a 5-bit shamt; bit 25 set means a malformed shift
        if (XLEN == 64) begin
          dec_imm = XLEN'(in_instr[25:20]);
        end else begin
          dec_imm     = XLEN'(in_instr[24:20]);
          dec_illegal = in_instr[25];
        end
      end
      3'b110:  dec_imm = XLEN'(in_instr[19:15]);
      default: dec_imm = '0;
    endcase
  end

  assign new_ent   = {dec_imm, in_tag, dec_illegal};
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_imm     = ent0_q[EW-1 -: XLEN];
  assign out_tag     = ent0_q[TAG_W:1];
  assign out_illegal = ent0_q[0];
  assign err_sticky  = err_q;

  // ent0 is always the head, so the output path is register-only
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    err_d   = err_q | (push & dec_illegal);
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) ent0_d = new_ent;
        else                 ent1_d = new_ent;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        ent0_d  = ent1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // push with pop only happens at occupancy 1
        ent0_d = new_ent;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate width; legal values 32 and 64 only.
REQ-002 SHALL have parameter TAG_W, default 5, width of the sideband tag carried with each immediate.
REQ-003 SHALL have input clk, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have input rst_n, 1; reset is asynchronous and active-low.
REQ-005 SHALL have input in_valid, 1, an instruction is offered.
REQ-006 SHALL have output in_ready, 1, the block accepts the instruction this cycle.
REQ-007 SHALL have input in_instr, 32, the raw instruction word.
REQ-008 SHALL have input in_ext_op, 3, the immediate format select.
REQ-009 SHALL have input in_tag, TAG_W, sideband passed through unchanged.
REQ-010 SHALL have output out_valid, 1, a decoded immediate is presented.
REQ-011 SHALL have input out_ready, 1, the consumer takes the output this cycle.
REQ-012 SHALL have output out_imm, XLEN, the decoded immediate.
REQ-013 SHALL have output out_tag, TAG_W, the tag of the presented entry.
REQ-014 SHALL have output out_illegal, 1, the presented entry had an illegal encoding.
REQ-015 SHALL have output err_sticky, 1, set on any accepted illegal entry; cleared only by reset.

Function
REQ-016 SHALL decode in_ext_op with sign extension from instr[31] to XLEN as: 000 I {instr[31:20]}; 001 U {instr[31:12],12'b0}; 010 S {instr[31:25],instr[11:7]}; 011 B {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}; 100 J {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}.
REQ-017 SHALL, for 101 (shift), output the zero-extended shamt: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64; funct7 bits never reach out_imm.
REQ-018 SHALL, for 110 (CSR), output the zero-extended instr[19:15].
REQ-019 SHALL, for 111, output all zeros.
REQ-020 SHALL flag illegal when XLEN=32, in_ext_op=101 and instr[25]=1; out_imm still follows REQ-017.
REQ-021 SHALL accept an input on the cycle in_valid and in_ready are both high; out_valid plus out_ready high completes an output.
REQ-022 SHALL hold internal storage of exactly two entries, each {imm, tag, illegal}, read in FIFO order.
REQ-023 SHALL drive in_ready high whenever occupancy is below 2, combinationally, with no dependence on out_ready.
REQ-024 SHALL present an entry at latency 1: accepted at edge N, out_valid high after edge N.
REQ-025 SHALL sustain one accept and one completion per cycle indefinitely when out_ready is held high.
REQ-026 SHALL, on simultaneous accept and completion, keep occupancy unchanged and preserve order; at occupancy 2 only a completion is possible.
REQ-027 SHALL keep out_imm, out_tag and out_illegal stable while out_valid is high and out_ready is low.
REQ-028 SHALL set err_sticky on the edge that accepts an illegal entry.
REQ-029 SHALL decode combinationally before the storage register; no decode logic sits on the output path.

Reset
REQ-030 SHALL, while rst_n is low, force occupancy 0, out_valid 0, out_imm 0, out_tag 0, out_illegal 0 and err_sticky 0, asynchronously.
REQ-031 SHALL ignore inputs while rst_n is low and discard held entries on reset mid-operation; in_ready is 1 on the first cycle after release.

Verification
REQ-032 SHALL check I and B: 0xFFF00093/000 -> out_imm 0xFFFFFFFF; 0xFE000EE3/011 -> 0xFFFFFFFC; each exactly one cycle after accept.
REQ-033 SHALL check shift and CSR at XLEN=32: 0x4030D093/101 -> 0x00000003, illegal 0; 0x000FD073/110 -> 0x0000001F; 0x0200D093/101 -> out_illegal 1, err_sticky 1 from the next cycle.
REQ-034 SHALL check backpressure: out_ready 0, offer tags 1,2,3 back-to-back -> tags 1,2 accepted, in_ready 0 for tag 3; raise out_ready -> outputs 1,2,3 in order, none lost or duplicated.
REQ-035 SHALL check streaming: 100 random instructions with out_ready high -> 100 outputs on consecutive cycles matching a reference decode.
REQ-036 SHALL check reset mid-operation: two entries held, pulse rst_n low between edges -> out_valid 0 and err_sticky 0 immediately, in_ready 1 after release, no stale output.
REQ-037 SHALL check XLEN=64: 0x03F0D093/101 -> out_imm 0x000000000000003F, illegal 0; 0x800000B7/001 -> 0xFFFFFFFF80000000.
